// File: rtl/mul_issue.sv
// mul_issue: issue stage between decode and a multi-cycle multiplier unit.
// Accepts one request, starts the multiplier, holds the result for writeback,
// handles pipeline flush and a watchdog on multiplier completion.
module mul_issue #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        mu_start,
  output logic [31:0] mu_a,
  output logic [31:0] mu_b,
  output logic [1:0]  mu_mulctl,
  input  logic [31:0] mu_mulres,
  input  logic        mu_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

  state_t         state, state_nxt;
  logic           ready_en;
  logic [WDW-1:0] wd_cnt;
  logic           wd_fire;
  logic           accept;
  logic           capture;
  logic           wd_set;

  // Watchdog expires on the TIMEOUT-th waiting cycle; a coincident mu_done wins.
  assign wd_fire = (wd_cnt == WDW'(TIMEOUT - 1)) && !mu_done;

  // Next-state, request handshake and capture strobes.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    capture   = 1'b0;
    wd_set    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ready_en && !flush;
        if (req_valid && req_ready) state_nxt = BUSY;
      end
      BUSY: begin
        if (mu_done) begin
          // Flush coinciding with completion discards the result directly.
          capture   = !flush;
          state_nxt = flush ? IDLE : RESP;
        end else if (wd_fire) begin
          wd_set    = 1'b1;
          state_nxt = IDLE;
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end
      RESP: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (rsp_ready) begin
          req_ready = ready_en;
          state_nxt = (req_valid && req_ready) ? BUSY : IDLE;
        end
      end
      DRAIN: begin
        if (mu_done) begin
          state_nxt = IDLE;
        end else if (wd_fire) begin
          wd_set    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    accept = req_valid && req_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request readiness is withheld until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Operand latch and one-cycle start pulse to the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mu_start  <= 1'b0;
      mu_a      <= '0;
      mu_b      <= '0;
      mu_mulctl <= '0;
      rsp_rd    <= '0;
    end else begin
      mu_start <= accept;
      if (accept) begin
        mu_a      <= req_a;
        mu_b      <= req_b;
        mu_mulctl <= req_op;
        rsp_rd    <= req_rd;
      end
    end
  end

  // Result capture and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (capture) rsp_data <= mu_mulres;
      rsp_valid <= (state_nxt == RESP);
      busy      <= (state_nxt != IDLE);
    end
  end

  // Watchdog counter: cleared with the start pulse, counts waiting cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (accept) begin
      wd_cnt <= '0;
    end else if (state == BUSY || state == DRAIN) begin
      wd_cnt <= wd_cnt + WDW'(1);
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      timeout_err <= 1'b0;
    else if (wd_set) timeout_err <= 1'b1;
  end

endmodule

// File: tb/tb_mul_issue.sv
// Scoreboard bench for mul_issue with an 8-cycle multiplier model.
module tb_mul_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [4:0]  req_rd;
  logic [31:0] req_a, req_b;
  logic        flush;
  logic        mu_start;
  logic [31:0] mu_a, mu_b;
  logic [1:0]  mu_mulctl;
  logic [31:0] mu_mulres;
  logic        mu_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        busy;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [36:0] exp_q[$];

  bit mdl_mute = 1'b0;
  int mdl_rem  = 0;

  mul_issue #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rd(req_rd),
    .req_a(req_a), .req_b(req_b), .flush(flush),
    .mu_start(mu_start), .mu_a(mu_a), .mu_b(mu_b), .mu_mulctl(mu_mulctl),
    .mu_mulres(mu_mulres), .mu_done(mu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdl_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00:   p = ua * ub;
      2'b01:   p = sa * sb;
      2'b10:   p = sa * ub;
      default: p = ua * ub;
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Multiplier model: mu_done 8 cycles after mu_start; not affected by DUT reset.
  always @(posedge clk) begin
    mu_done <= 1'b0;
    if (mu_start) begin
      mdl_rem   <= 7;
      mu_mulres <= mdl_mul(mu_mulctl, mu_a, mu_b);
    end else if (mdl_rem > 0) begin
      mdl_rem <= mdl_rem - 1;
      if (mdl_rem == 1 && !mdl_mute) mu_done <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready && !flush) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_data), 64'hDEAD_0000);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(e[31:0]));
          chk("rsp_rd", 64'(rsp_rd), 64'(e[36:32]));
        end
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit expect_rsp, input logic [31:0] exp);
    int n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (!req_ready) chk("issue_wait", 64'(req_ready), 64'd1);
    if (expect_rsp) exp_q.push_back({rd, exp});
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 60) begin tick(); n++; end
    chk("wait_rsp", 64'(rsp_valid), 64'd1);
  endtask

  initial begin
    int n;
    fork monitor(); join_none
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rd = '0; req_a = '0; req_b = '0;
    flush = 1'b0; rsp_ready = 1'b1;
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_outs", 64'({mu_start, rsp_valid, timeout_err, rsp_rd, mu_mulctl}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 64'(req_ready), 64'd1);

    // mul 7 * -3, latency check
    issue(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 1'b1, 32'hFFFF_FFEB);
    chk("start_pulse", 64'(mu_start), 64'd1);
    chk("mu_ops", {mu_a, mu_b}, {32'h0000_0007, 32'hFFFF_FFFD});
    chk("mu_ctl", 64'(mu_mulctl), 64'd0);
    chk("busy_c1", 64'(busy), 64'd1);
    chk("ready_busy", 64'(req_ready), 64'd0);
    tick();
    chk("start_one_cycle", 64'(mu_start), 64'd0);
    n = 2;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    chk("rsp_latency", 64'(n), 64'd10);
    tick(); tick();

    // mulhu with writeback stall
    rsp_ready = 1'b0;
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1, 32'hFFFF_FFFE);
    wait_rsp();
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_data", 64'(rsp_data), 64'hFFFF_FFFE);
      chk("stall_rd", 64'(rsp_rd), 64'd7);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("stall_done", 64'(rsp_valid), 64'd0);

    // mulh with rd=0
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd0, 1'b1, 32'h4000_0000);
    wait_rsp();
    tick();

    // back-to-back: second request accepted while in RESP
    rsp_ready = 1'b0;
    issue(2'b00, 32'd3, 32'd5, 5'd1, 1'b1, 32'h0000_000F);
    wait_rsp();
    rsp_ready = 1'b1; req_valid = 1'b1; req_op = 2'b10;
    req_a = 32'hFFFF_FFFF; req_b = 32'hFFFF_FFFF; req_rd = 5'd2;
    #1;
    chk("b2b_ready", 64'(req_ready), 64'd1);
    exp_q.push_back({5'd2, 32'hFFFF_FFFF});
    tick();
    req_valid = 1'b0;
    chk("b2b_start", 64'(mu_start), 64'd1);
    chk("b2b_valid_drop", 64'(rsp_valid), 64'd0);
    wait_rsp();
    tick();

    // flush 3 cycles after mu_start -> drain
    issue(2'b00, 32'd9, 32'd9, 5'd3, 1'b0, 32'd0);
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drain_busy", 64'(busy), 64'd1);
    n = 0;
    while (!mu_done && n < 30) begin
      chk("drain_no_valid", 64'(rsp_valid), 64'd0);
      tick(); n++;
    end
    chk("drain_done_seen", 64'(mu_done), 64'd1);
    tick();
    chk("drain_idle", 64'(busy), 64'd0);
    chk("drain_no_valid_end", 64'(rsp_valid), 64'd0);

    // flush in IDLE blocks accept
    req_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_idle_ready", 64'(req_ready), 64'd0);
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_nostart", 64'({mu_start, busy}), 64'd0);

    // flush in RESP with rsp_ready=1
    rsp_ready = 1'b0;
    issue(2'b00, 32'd2, 32'd2, 5'd4, 1'b0, 32'd0);
    wait_rsp();
    flush = 1'b1; rsp_ready = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_resp", 64'({rsp_valid, busy}), 64'd0);

    // watchdog timeout
    mdl_mute = 1'b1;
    issue(2'b00, 32'd1, 32'd1, 5'd6, 1'b0, 32'd0);
    n = 0;
    while (!timeout_err && n < 40) begin tick(); n++; end
    chk("timeout_cycles", 64'(n), 64'd16);
    chk("timeout_idle", 64'({busy, rsp_valid}), 64'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("timeout_sticky", 64'(timeout_err), 64'd1);
    mdl_mute = 1'b0;

    // reset during BUSY; late mu_done ignored
    issue(2'b00, 32'd4, 32'd4, 5'd8, 1'b0, 32'd0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", 64'({mu_start, rsp_valid, busy, timeout_err, req_ready}), 64'd0);
    chk("midrst_data", {mu_a, mu_b}, 64'd0);
    chk("midrst_misc", 64'({rsp_data, rsp_rd, mu_mulctl}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    while (!mu_done && n < 20) begin tick(); n++; end
    chk("late_done_seen", 64'(mu_done), 64'd1);
    tick();
    chk("late_done_ignored", 64'({rsp_valid, busy}), 64'd0);
    issue(2'b00, 32'h10, 32'h10, 5'd9, 1'b1, 32'h0000_0100);
    wait_rsp();
    tick();

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_issue.md
MUL_ISSUE -- requirements
Module: mul_issue

Interface
REQ-001 Parameter TIMEOUT, default 16: the maximum number of cycles allowed between mu_start and mu_done.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  decode presents a multiply request.
REQ-005 req_ready  output  1  block accepts the request this cycle.
REQ-006 req_op  input  2  operation: 00 mul, 01 mulh, 10 mulhsu, 11 mulhu.
REQ-007 req_rd  input  5  destination register tag, passed through to the response.
REQ-008 req_a, req_b  input  32 each  source operands.
REQ-009 flush  input  1  pipeline kill; squashes any in-flight request.
REQ-010 mu_start  output  1  one-cycle start pulse to the multiplier unit.
REQ-011 mu_a, mu_b  output  32 each  operands to the multiplier unit.
REQ-012 mu_mulctl  output  2  operation select to the multiplier unit, equal to the latched req_op.
REQ-013 mu_mulres  input  32  multiplier result, valid in the cycle mu_done is high.
REQ-014 mu_done  input  1  multiplier completion pulse.
REQ-015 rsp_valid  output  1  writeback result available.
REQ-016 rsp_ready  input  1  writeback consumes the result.
REQ-017 rsp_data  output  32  multiply result.
REQ-018 rsp_rd  output  5  destination tag of the result.
REQ-019 busy  output  1  high in every state except IDLE; used as the decode stall.
REQ-020 timeout_err  output  1  sticky watchdog error flag.

Function
REQ-021 The block SHALL implement a four-state FSM: IDLE, BUSY, RESP and DRAIN.
REQ-022 req_ready SHALL be 1 in IDLE, 1 in RESP only while rsp_ready=1, 0 in BUSY and DRAIN, and 0 in any cycle where flush=1.
REQ-023 On an accept (req_valid & req_ready), the block SHALL latch req_a, req_b, req_op and req_rd, and SHALL go to BUSY.
REQ-024 mu_start SHALL pulse high for exactly one cycle, in the cycle after the accept.
REQ-025 mu_a, mu_b and mu_mulctl SHALL be registered, and SHALL be held stable from mu_start until the matching mu_done or until the watchdog fires.
REQ-026 In BUSY, when mu_done=1, the block SHALL capture mu_mulres into rsp_data and SHALL go to RESP.
- With the multiplier's 8-cycle latency: accept at cycle 0, mu_start at cycle 1, mu_done at cycle 9, rsp_valid at cycle 10.
REQ-027 In RESP, rsp_valid, rsp_data and rsp_rd SHALL be held stable until rsp_ready=1.
- rsp_ready=1 with req_valid=0 SHALL go to IDLE.
- rsp_ready=1 with req_valid=1 SHALL accept the new request the same cycle and go to BUSY.
REQ-028 A request with req_rd=0 SHALL be executed and delivered like any other request.
REQ-029 flush in BUSY SHALL go to DRAIN; DRAIN SHALL wait for mu_done, discard the result, raise no rsp_valid, and then go to IDLE.
REQ-030 flush in RESP SHALL deassert rsp_valid in the next cycle and go to IDLE, even if rsp_ready=1 in the same cycle.
REQ-031 flush in IDLE with req_valid=1 SHALL block the accept.
REQ-032 mu_done received in IDLE or RESP SHALL be ignored.
REQ-033 A watchdog counter SHALL clear at mu_start and increment each cycle in BUSY and DRAIN.
- When the counter reaches TIMEOUT without mu_done, timeout_err SHALL be set and the FSM SHALL go to IDLE with no response.
- mu_done and timeout in the same cycle: mu_done SHALL win.
REQ-034 timeout_err SHALL remain set until reset.

Reset
REQ-035 While rst_n=0, asynchronously: the FSM SHALL be in IDLE, and mu_start, rsp_valid, busy, timeout_err and the watchdog counter SHALL be 0.
- req_ready SHALL be 0 while rst_n=0, and SHALL be 1 from the first rising edge after reset release.
REQ-036 mu_a, mu_b, mu_mulctl, rsp_data and rsp_rd SHALL reset to 0.
REQ-037 Reset asserted mid-operation SHALL abandon the operation; a late mu_done after reset release SHALL be ignored per REQ-032.

Verification
REQ-038 mul: a=0x00000007, b=0xFFFFFFFD, op=00, rd=5, multiplier model with 8-cycle latency -> rsp_valid at cycle 10, rsp_data=0xFFFFFFEB, rsp_rd=5.
REQ-039 mulhu: a=b=0xFFFFFFFF, op=11, rsp_ready held 0 for 3 cycles -> rsp_data=0xFFFFFFFE held stable while stalled; handshake completes on the 4th cycle.
REQ-040 Back-to-back: a second request arrives while in RESP with rsp_ready=1 -> accepted the same cycle, mu_start the next cycle, two responses delivered in order.
REQ-041 flush 3 cycles after mu_start -> DRAIN, mu_done consumed, no rsp_valid, busy=0 in the cycle after mu_done.
REQ-042 Multiplier model never asserts mu_done, TIMEOUT=16 -> timeout_err=1 16 cycles after mu_start, FSM in IDLE, and it stays set until rst_n=0.
REQ-043 rst_n pulsed low at cycle 4 of BUSY -> all outputs 0 immediately; mu_done at cycle 9 ignored; the next request completes normally.
